cmd_arb: RTL
============

CMD_ARB -- requirements
Module: cmd_arb

Interface
REQ-001 Parameter CMD_SIZE SHALL default to 80 and give the command width; bit CMD_SIZE-1 is the command valid bit.
REQ-002 Parameter NUM_REQ SHALL default to 4 and give the number of core requesters; the arbiter logic is fixed at 4, and unused requesters present valid=0.
REQ-003 Clocking and reset SHALL be one clock, with reset synchronous and active-high.
REQ-004 clk  in  1  SHALL be the single clock.
REQ-005 rst  in  1  SHALL be the synchronous active-high reset.
REQ-006 cmd_in_0  in  4*CMD_SIZE  SHALL carry the channel-0 (instruction) commands, with core k at bits [(k+1)*CMD_SIZE-1 : k*CMD_SIZE].
REQ-007 cmd_in_1  in  4*CMD_SIZE  SHALL carry the channel-1 (data) commands, packed the same way.
REQ-008 stall  in  4  SHALL mask all requests from core k while bit k is 1 (SMP hold).
REQ-009 bus_rdy_0, bus_rdy_1  in  1 each  SHALL indicate that the bus side of the channel can accept a command.
REQ-010 rsp_done_0, rsp_done_1  in  1 each  SHALL pulse when the bus response for the outstanding channel command completes.
REQ-011 cmd_tkn  out  8  SHALL be the taken pulses, with bit 2k+n for core k, channel n.
REQ-012 cmd_out_0, cmd_out_1  out  CMD_SIZE each  SHALL carry the registered granted command per channel.
REQ-013 owner_0, owner_1  out  2 each  SHALL give the core ID of the last or outstanding grant per channel.
REQ-014 busy  out  2  SHALL be 1 for channel n whenever channel n is not IDLE.

Function
REQ-015 Channels 0 and 1 SHALL be arbitrated independently, each with its own FSM and round-robin pointer.
REQ-016 Each channel FSM SHALL have exactly three states: IDLE, ISSUE, WAIT.
REQ-017 For channel n, core k SHALL be eligible when cmd_in_n[k] valid=1 and stall[k]=0.
REQ-018 IDLE->ISSUE SHALL occur on the clock edge where bus_rdy_n=1 and at least one core is eligible.
REQ-019 The winner SHALL be the first eligible core scanning ptr_n, ptr_n+1, ... modulo 4.
REQ-020 On the IDLE->ISSUE edge the block SHALL register the winner's full command into cmd_out_n, set owner_n to the winner, and set ptr_n to (winner+1) mod 4.
REQ-021 In ISSUE (exactly one cycle) cmd_out_n valid SHALL be 1 and cmd_tkn[2*winner+n] SHALL be 1; all other cmd_tkn bits for channel n SHALL be 0.
REQ-022 ISSUE SHALL always leave after one cycle: ->IDLE if rsp_done_n=1 in that cycle, else ->WAIT.
REQ-023 In WAIT, cmd_out_n valid SHALL be 0; the payload bits and owner_n SHALL hold their values.
REQ-024 WAIT->IDLE SHALL occur on the edge where rsp_done_n=1.
REQ-025 rsp_done_n in IDLE SHALL be ignored.
REQ-026 Grant-to-bus latency SHALL be one cycle (request seen at edge t, cmd_out valid during cycle t+1), and a channel SHALL issue at most one command per 2 cycles.
REQ-027 cmd_tkn SHALL be a single-cycle pulse per grant, never asserted outside ISSUE.
REQ-028 A stalled or invalid core SHALL be skipped without advancing the pointer past it unless another core wins.
REQ-029 If requests drop while the channel is in ISSUE/WAIT, the block SHALL take no action; the command in flight completes.
REQ-030 When both channels grant on the same edge, both corresponding cmd_tkn bits SHALL pulse together, including two bits for the same core.
REQ-031 bus_rdy_n SHALL be sampled only in IDLE; a drop of bus_rdy_n in ISSUE/WAIT SHALL have no effect.
REQ-032 The pointer arithmetic SHALL be 2-bit, wrapping 3->0.

Reset
REQ-033 On rst=1 at an edge, both FSMs SHALL go to IDLE, ptr_0=ptr_1=0, cmd_out_0=cmd_out_1=0, owner_0=owner_1=0, cmd_tkn=0 and busy=0, overriding every other input.
REQ-034 Reset mid-operation (ISSUE or WAIT) SHALL abandon the outstanding command; a later rsp_done for it SHALL be ignored in IDLE.
REQ-035 rst SHALL take priority over simultaneous grant or rsp_done.

Verification
REQ-036 Single request: core 2 ch1 valid, bus_rdy_1=1 -> next cycle cmd_out_1 = core 2 command, cmd_tkn=8'b0010_0000, owner_1=2, then WAIT until rsp_done_1.
REQ-037 Round-robin: all 4 cores valid on ch0 continuously, rsp_done_0 asserted in every WAIT -> grant order 0,1,2,3,0, and each cmd_tkn bit pulses once per grant.
REQ-038 Stall/skip: cores 0,1 valid, stall=4'b0001 -> core 1 is granted and ptr_0 becomes 2; after stall clears, core 0 is granted next.
REQ-039 Both channels: core 3 valid on ch0 and ch1, both bus_rdy high -> cmd_tkn=8'b1100_0000 in the same cycle.
REQ-040 Boundary: bus_rdy_0=0 with requests pending -> no grant and cmd_tkn=0; rsp_done_0 in ISSUE -> channel returns to IDLE the next cycle.
REQ-041 Reset in WAIT on ch1 -> busy=0, cmd_out_1=0 and owner_1=0; a stray rsp_done_1 pulse after reset produces no state change.

Source files
------------

// File: rtl/cmd_arb.sv
// Two-channel round-robin command arbiter: 4 cores contend independently on channel 0 (instr) and channel 1 (data).
// Latency: request seen at edge t, registered command valid on cmd_out_n during cycle t+1 (ISSUE); at most one grant per 2 cycles.
// Backpressure: grants only from IDLE while bus_rdy_n=1; channel then holds off new grants until rsp_done_n (WAIT).
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   cmd_in_0/1             4 packed commands per channel, core k at [(k+1)*CMD_SIZE-1 : k*CMD_SIZE], MSB = valid
//   stall                  per-core request mask (bit k masks core k on both channels)
//   bus_rdy_0/1            bus side can accept a command (sampled in IDLE only)
//   rsp_done_0/1           response for the outstanding channel command completed
//   cmd_tkn                taken pulses, bit 2k+n for core k on channel n
//   cmd_out_0/1            registered granted command; MSB high only during ISSUE
//   owner_0/1              core ID of last/outstanding grant
//   busy                   bit n set while channel n is not IDLE

module cmd_arb #(
   parameter int CMD_SIZE = 80,
   parameter int NUM_REQ  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*CMD_SIZE-1:0] cmd_in_0,
   input  logic [4*CMD_SIZE-1:0] cmd_in_1,
   input  logic [3:0]            stall,
   input  logic                  bus_rdy_0,
   input  logic                  bus_rdy_1,
   input  logic                  rsp_done_0,
   input  logic                  rsp_done_1,
   output logic [7:0]            cmd_tkn,
   output logic [CMD_SIZE-1:0]   cmd_out_0,
   output logic [CMD_SIZE-1:0]   cmd_out_1,
   output logic [1:0]            owner_0,
   output logic [1:0]            owner_1,
   output logic [1:0]            busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // Channel-indexed views so both channels share one generate body.
   logic [1:0][4*CMD_SIZE-1:0] cmd_in_v;
   logic [1:0]                 bus_rdy_v;
   logic [1:0]                 rsp_done_v;
   logic [1:0][CMD_SIZE-1:0]   cmd_out_v;
   logic [1:0][1:0]            owner_v;
   logic [1:0][3:0]            tkn_v;

   assign cmd_in_v[0]   = cmd_in_0;
   assign cmd_in_v[1]   = cmd_in_1;
   assign bus_rdy_v     = {bus_rdy_1, bus_rdy_0};
   assign rsp_done_v    = {rsp_done_1, rsp_done_0};
   assign cmd_out_0     = cmd_out_v[0];
   assign cmd_out_1     = cmd_out_v[1];
   assign owner_0       = owner_v[0];
   assign owner_1       = owner_v[1];

   // Interleave per-channel one-hot grants into bit 2k+n.
   assign cmd_tkn = {tkn_v[1][3], tkn_v[0][3], tkn_v[1][2], tkn_v[0][2],
                     tkn_v[1][1], tkn_v[0][1], tkn_v[1][0], tkn_v[0][0]};

   for (genvar n = 0; n < 2; n++) begin : g_ch
      logic [1:0]          state_q, state_d;
      logic [1:0]          ptr_q, ptr_d;
      logic [1:0]          owner_q, owner_d;
      logic [CMD_SIZE-1:0] cmd_q, cmd_d;
      logic [3:0]          elig;
      logic [1:0]          win;
      logic                win_vld;

      // Requesters beyond NUM_REQ are never eligible even if their inputs float.
      always_comb begin
         for (int k = 0; k < 4; k++) begin
            elig[k] = (k < NUM_REQ) && cmd_in_v[n][k*CMD_SIZE + CMD_SIZE - 1] && !stall[k];
         end
      end

      // Scan from the far end back to ptr so the entry closest to ptr overwrites last
      // and wins; the 2-bit add wraps 3->0 naturally.
      always_comb begin
         win     = ptr_q;
         win_vld = 1'b0;
         for (int i = 3; i >= 0; i--) begin
            if (elig[ptr_q + 2'(i)]) begin
               win     = ptr_q + 2'(i);
               win_vld = 1'b1;
            end
         end
      end

      always_comb begin
         state_d = state_q;
         ptr_d   = ptr_q;
         owner_d = owner_q;
         cmd_d   = cmd_q;
         case (state_q)
            ST_IDLE: begin
               if (bus_rdy_v[n] && win_vld) begin
                  state_d = ST_ISSUE;
                  cmd_d   = cmd_in_v[n][win*CMD_SIZE +: CMD_SIZE];
                  owner_d = win;
                  ptr_d   = win + 2'd1;
               end
            end
            ST_ISSUE: begin
               // Payload is kept for debug visibility; only the valid bit drops.
               cmd_d[CMD_SIZE-1] = 1'b0;
               state_d = rsp_done_v[n] ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
               if (rsp_done_v[n]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cmd_q   <= '0;
         end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
         end
      end

      assign cmd_out_v[n] = cmd_q;
      assign owner_v[n]   = owner_q;
      assign busy[n]      = (state_q != ST_IDLE);
      assign tkn_v[n]     = (state_q == ST_ISSUE) ? (4'b0001 << owner_q) : 4'b0000;
   end

endmodule
